// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - 32x32 sequential multiplier built from a shared external 16x16 multiplier
// Define MULT32_KARATSUBA_EN for the 3-product Karatsuba schedule; default is the 4-product schoolbook schedule.
module mult32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        done,
    output logic [63:0] P,
    output logic        m_start,
    output logic [15:0] m_A,
    output logic [15:0] m_B,
    input  logic        m_done,
    input  logic [31:0] m_P
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_COMBINE = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

`ifdef MULT32_KARATSUBA_EN
    localparam int         N_OPS   = 3;
    localparam logic [1:0] LAST_OP = 2'd2;
`else
    localparam int         N_OPS   = 4;
    localparam logic [1:0] LAST_OP = 2'd3;
`endif

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] sp_q [N_OPS];
    logic [31:0] sp_d [N_OPS];
    logic [63:0] p_q, p_d;
    logic        done_q, done_d;
    logic [63:0] product_c;

    // Holding off in ISSUE while m_done is high also covers a multiplier left busy by a reset.
    assign m_start = (state_q == S_ISSUE) && !m_done;
    assign done    = done_q;
    assign P       = p_q;

`ifdef MULT32_KARATSUBA_EN
    logic [16:0] sa, sb;
    logic [63:0] z2_w, z0_w, zm_w, mid_w;

    assign sa = {1'b0, a_q[31:16]} + {1'b0, a_q[15:0]};
    assign sb = {1'b0, b_q[31:16]} + {1'b0, b_q[15:0]};

    always_comb begin
        m_A = sa[15:0];
        m_B = sb[15:0];
        case (op_q)
            2'd0: begin m_A = a_q[31:16]; m_B = b_q[31:16]; end
            2'd1: begin m_A = a_q[15:0];  m_B = b_q[15:0];  end
            default: ;
        endcase
    end

    // The 16x16 unit only sees the low 16 bits of sa/sb; the carry-bit cross terms are restored here.
    always_comb begin
        z2_w  = {32'd0, sp_q[0]};
        z0_w  = {32'd0, sp_q[1]};
        zm_w  = {32'd0, sp_q[2]}
              + (sa[16] ? {32'd0, sb[15:0], 16'd0} : 64'd0)
              + (sb[16] ? {32'd0, sa[15:0], 16'd0} : 64'd0)
              + ((sa[16] & sb[16]) ? 64'h0000_0001_0000_0000 : 64'd0);
        mid_w     = zm_w - z2_w - z0_w;
        product_c = (z2_w << 32) + (mid_w << 16) + z0_w;
    end
`else
    always_comb begin
        m_A = a_q[15:0];
        m_B = b_q[15:0];
        case (op_q)
            2'd0: begin m_A = a_q[31:16]; m_B = b_q[31:16]; end
            2'd1: begin m_A = a_q[31:16]; m_B = b_q[15:0];  end
            2'd2: begin m_A = a_q[15:0];  m_B = b_q[31:16]; end
            default: ;
        endcase
    end

    always_comb begin
        product_c = ({32'd0, sp_q[0]} << 32)
                  + (({32'd0, sp_q[1]} + {32'd0, sp_q[2]}) << 16)
                  + {32'd0, sp_q[3]};
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sp_d    = sp_q;
        p_d     = p_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!m_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    sp_d[op_q] = m_P;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!m_done) begin
                    if (op_q == LAST_OP) begin
                        state_d = S_COMBINE;
                    end else begin
                        op_d    = op_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_COMBINE: begin
                p_d     = product_c;
                done_d  = 1'b1;
                state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            p_q     <= 64'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_OPS; i++) sp_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            done_q  <= done_d;
            for (int i = 0; i < N_OPS; i++) sp_q[i] <= sp_d[i];
        end
    end

endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - directed-vector bench for mult32_seq with a 5-cycle 16x16 multiplier model
module tb_mult32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic        done;
    logic [63:0] P;
    logic        m_start;
    logic [15:0] m_A, m_B;
    logic        m_done = 1'b0;
    logic [31:0] m_P = 32'd0;

`ifdef MULT32_KARATSUBA_EN
    localparam int N_OPS = 3;
`else
    localparam int N_OPS = 4;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int viol = 0;
    int done_cnt = 0;
    int ms_cnt = 0;
    logic done_prev = 1'b0;

    logic [2:0]  busy_cnt = 3'd0;
    logic [1:0]  hold_cnt = 2'd0;
    logic [15:0] ma_q = 16'd0, mb_q = 16'd0;

    mult32_seq dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .done(done), .P(P), .m_start(m_start), .m_A(m_A), .m_B(m_B),
        .m_done(m_done), .m_P(m_P)
    );

    always #5 clk = ~clk;

    // Multiplier model: not reset, restarts on m_start, done raised after 5 cycles and held for 2.
    always @(posedge clk) begin
        if (m_start) begin
            busy_cnt <= 3'd5;
            ma_q     <= m_A;
            mb_q     <= m_B;
            m_done   <= 1'b0;
            hold_cnt <= 2'd0;
        end else if (busy_cnt != 3'd0) begin
            busy_cnt <= busy_cnt - 3'd1;
            if (busy_cnt == 3'd1) begin
                m_done   <= 1'b1;
                m_P      <= {16'd0, ma_q} * {16'd0, mb_q};
                hold_cnt <= 2'd2;
            end
        end else if (hold_cnt != 2'd0) begin
            hold_cnt <= hold_cnt - 2'd1;
            if (hold_cnt == 2'd1) m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            if (m_start && m_done) viol <= viol + 1;
            if (done && done_prev) viol <= viol + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (m_start) ms_cnt <= ms_cnt + 1;
            done_prev <= done;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit poke, input bit b2b);
        int d0, m0;
        bit seen;
        @(negedge clk);
        d0 = done_cnt;
        m0 = ms_cnt;
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (poke && i == 12) begin start = 1'b1; A = 32'hDEAD0001; B = 32'h0000BEEF; end
            if (poke && i == 13) start = 1'b0;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " P"}, P, exp);
        if (!b2b) begin
            repeat (3) @(negedge clk);
            check({tag, " P_held"}, P, exp);
            check({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
            check({tag, " m_start_pulses"}, 64'(ms_cnt - m0), 64'(N_OPS));
        end
    endtask

    initial begin
        int m0, d0;
        rst = 1'b1; start = 1'b1; A = 32'd3; B = 32'd4;
        repeat (3) @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset P", P, 64'd0);
        check("reset m_start", 64'(m_start), 64'd0);
        check("reset m_A", 64'(m_A), 64'd0);
        check("reset m_B", 64'(m_B), 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_over_start no issue", 64'(ms_cnt), 64'd0);

        run_op("3x4",        32'd3,          32'd4,          64'h0000_0000_0000_000C, 1'b0, 1'b0);
        run_op("ones",       32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
        run_op("carry16",    32'h80008000,   32'h80008000,   64'h4000_8000_4000_0000, 1'b0, 1'b0);
        run_op("mixed_poke", 32'h12345678,   32'h9ABCDEF0,   64'h0B00_EA4E_242D_2080, 1'b1, 1'b0);
        run_op("zero",       32'd0,          32'hDEADBEEF,   64'd0,                   1'b0, 1'b0);
        run_op("ffffsq",     32'h0000FFFF,   32'h0000FFFF,   64'h0000_0000_FFFE_0001, 1'b0, 1'b1);
        run_op("b2b one",    32'd1,          32'hFFFFFFFF,   64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);

        // Abort during the second WAIT.
        @(negedge clk);
        m0 = ms_cnt;
        A = 32'h00050000; B = 32'h00070003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && (ms_cnt - m0) < 2; i++) @(negedge clk);
        check("abort reached 2nd issue", 64'(ms_cnt - m0), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort done", 64'(done), 64'd0);
        check("abort P", P, 64'd0);
        check("abort m_start", 64'(m_start), 64'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        run_op("after_abort", 32'h00010000, 32'h00010000, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        check("abort no stray done", 64'(done_cnt - d0), 64'd1);

        check("protocol violations", 64'(viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
